uart_rx: RTL

//  8N1 UART receiver, fixed baud set by parameters; pairs with the design's 8N1 transmitter.

---
 rtl/uart_rx.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a fixed baud rate. Samples mid-bit using a divider that restarts
// on each start edge and emits one-cycle valid/error strobes per frame.
module uart_rx #(
    parameter int unsigned clk_freq  = 27000000,
    parameter int unsigned uart_freq = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_p,
    output logic [7:0] dout,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       rx_busy
);

    localparam int unsigned CLKS_PER_BIT = clk_freq / uart_freq;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned DIV_W        = $clog2(CLKS_PER_BIT) + 1;
    localparam int unsigned BIT_W        = 3;

    localparam logic [DIV_W-1:0] DIV_FULL = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(HALF_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(7);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state, state_next;
    logic               rx_m, rx_s, rx_d;
    logic [DIV_W-1:0]   div, div_next;
    logic [BIT_W-1:0]   bitcnt, bitcnt_next;
    logic [7:0]         shift, shift_next;
    logic [7:0]         dout_next;
    logic               valid_next, err_next;
    logic               fall;

    // Two-flop synchronizer plus one delay stage for falling-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx_p;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    assign fall = rx_d & ~rx_s;

    // State and datapath registers; rx_busy tracks the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            div      <= '0;
            bitcnt   <= '0;
            shift    <= '0;
            dout     <= 8'h00;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            rx_busy  <= 1'b0;
        end else begin
            state    <= state_next;
            div      <= div_next;
            bitcnt   <= bitcnt_next;
            shift    <= shift_next;
            dout     <= dout_next;
            rx_valid <= valid_next;
            rx_err   <= err_next;
            rx_busy  <= (state_next != IDLE);
        end
    end

    // Next-state and datapath logic; the divider clears on every transition.
    always_comb begin
        state_next  = state;
        div_next    = div;
        bitcnt_next = bitcnt;
        shift_next  = shift;
        dout_next   = dout;
        valid_next  = 1'b0;
        err_next    = 1'b0;

        unique case (state)
            IDLE: begin
                div_next = '0;
                if (fall) begin
                    state_next = START;
                end
            end

            START: begin
                if (div == DIV_HALF) begin
                    div_next = '0;
                    if (!rx_s) begin
                        state_next  = DATA;
                        bitcnt_next = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    div_next = div + DIV_W'(1);
                end
            end

            DATA: begin
                if (div == DIV_FULL) begin
                    div_next   = '0;
                    shift_next = {rx_s, shift[7:1]};
                    if (bitcnt == BIT_LAST) begin
                        state_next  = STOP;
                        bitcnt_next = '0;
                    end else begin
                        bitcnt_next = bitcnt + BIT_W'(1);
                    end
                end else begin
                    div_next = div + DIV_W'(1);
                end
            end

            STOP: begin
                if (div == DIV_FULL) begin
                    div_next   = '0;
                    state_next = IDLE;
                    if (rx_s) begin
                        dout_next  = shift;
                        valid_next = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end else begin
                    div_next = div + DIV_W'(1);
                end
            end

            default: begin
                state_next = IDLE;
                div_next   = '0;
            end
        endcase
    end

endmodule
